// File: rtl/ftb_update_encoder_pkg.sv
// Frontend shared types for the FTB write path: the commit update bundle, the compressed
// entry format, and the encode helpers that are the inverse of the lookup-side decode.
package ftb_update_encoder_pkg;

    localparam int XLEN               = 32;
    localparam int FTB_TAG_WIDTH      = 16;
    localparam int FTB_FALLTHRU_WIDTH = 12;
    localparam int FTB_TARGET_WIDTH   = 20;
    localparam int FT_UP_W            = XLEN - FTB_FALLTHRU_WIDTH - 1;
    localparam int TG_UP_W            = XLEN - FTB_TARGET_WIDTH - 1;

    typedef enum logic [1:0] {BR_NONE, BR_COND, BR_DIRECT, BR_INDIRECT} BranchType_t;
    typedef enum logic [1:0] {TAR_FIT, TAR_OVF, TAR_UDF} tarStat_t;

    typedef struct packed {
        logic [XLEN-1:0] startAddr;
        logic [XLEN-1:0] fallthru;
        logic [XLEN-1:0] target;
        logic            taken;
        BranchType_t     branch_type;
        logic            hit_on_ftb;
        logic [1:0]      old_counter;
    } ftbUpdReq_t;

    typedef struct packed {
        logic                          vld;
        logic [FTB_TAG_WIDTH-1:0]      tag;
        logic [FTB_FALLTHRU_WIDTH-1:0] fallthruAddr;
        logic                          carry;
        logic [FTB_TARGET_WIDTH-1:0]   targetAddr;
        tarStat_t                      tarStat;
        BranchType_t                   branch_type;
        logic [1:0]                    counter;
    } ftbEntry_t;

    function automatic logic [1:0] counterUpdate(input logic [1:0] old, input logic taken);
        logic [1:0] r;
        r = old;
        if (taken && old != 2'd3)       r = old + 2'd1;
        else if (!taken && old != 2'd0) r = old - 2'd1;
        return r;
    endfunction

    function automatic ftbEntry_t encodeEntry(input ftbUpdReq_t u, input int idx_w);
        ftbEntry_t            e;
        logic [XLEN-1:0]      sh;
        logic [TG_UP_W-1:0]   tdiff;
        e            = '0;
        sh           = u.startAddr >> (idx_w + 1);
        e.vld        = 1'b1;
        e.tag        = sh[FTB_TAG_WIDTH-1:0];
        e.fallthruAddr = u.fallthru[FTB_FALLTHRU_WIDTH:1];
        e.carry      = u.fallthru[XLEN-1:FTB_FALLTHRU_WIDTH+1] != u.startAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1];
        e.targetAddr = u.target[FTB_TARGET_WIDTH:1];
        tdiff        = u.target[XLEN-1:FTB_TARGET_WIDTH+1] - u.startAddr[XLEN-1:FTB_TARGET_WIDTH+1];
        if (tdiff == '0)                  e.tarStat = TAR_FIT;
        else if (tdiff == TG_UP_W'(1))    e.tarStat = TAR_OVF;
        else                              e.tarStat = TAR_UDF;
        e.branch_type = u.branch_type;
        if (u.hit_on_ftb) e.counter = counterUpdate(u.old_counter, u.taken);
        else              e.counter = u.taken ? 2'd2 : 2'd1;
        return e;
    endfunction

    // Upper-bit deltas wrap at field width, so an all-ones start region followed by zero is +1.
    function automatic logic isEncodable(input ftbUpdReq_t u);
        logic [FT_UP_W-1:0] fdiff;
        logic [TG_UP_W-1:0] tdiff;
        fdiff = u.fallthru[XLEN-1:FTB_FALLTHRU_WIDTH+1] - u.startAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1];
        tdiff = u.target[XLEN-1:FTB_TARGET_WIDTH+1] - u.startAddr[XLEN-1:FTB_TARGET_WIDTH+1];
        return (fdiff == '0 || fdiff == FT_UP_W'(1)) &&
               (tdiff == '0 || tdiff == TG_UP_W'(1) || tdiff == '1);
    endfunction

endpackage

// File: rtl/ftb_update_encoder_fifo.sv
// Generic synchronous FIFO for buffered FTB updates; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate count.
module ftb_upd_fifo
    import ftb_update_encoder_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ftbUpdReq_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output logic o_empty,
    output T     o_head
);
    localparam int AW = $clog2(DEPTH);

    T             r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_wr;
    logic         w_rd;

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ftb_update_encoder.sv
// Buffers committed branch updates and issues one encoded FTB write per cycle.
// Define FTB_UPD_RANGE_CHECK_EN to drop (and count) updates the entry format cannot represent.
module ftb_update_encoder
    import ftb_update_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_upd_vld,
    output logic                 o_upd_rdy,
    input  logic [XLEN-1:0]      i_upd_startAddr,
    input  logic [XLEN-1:0]      i_upd_fallthru,
    input  logic [XLEN-1:0]      i_upd_target,
    input  logic                 i_upd_taken,
    input  BranchType_t          i_upd_branch_type,
    input  logic                 i_upd_hit_on_ftb,
    input  logic [1:0]           i_upd_old_counter,
    output logic                 o_ftb_wr_vld,
    input  logic                 i_ftb_wr_rdy,
    output logic [IDX_WIDTH-1:0] o_ftb_wr_idx,
    output ftbEntry_t            o_ftb_wr_entry,
    output logic [15:0]          o_drop_cnt
);
    ftbUpdReq_t w_req;
    ftbUpdReq_t w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_free;
    logic       w_take;
    logic       w_drop;
    logic       w_load;

    logic                 r_vld;
    logic [IDX_WIDTH-1:0] r_idx;
    ftbEntry_t            r_entry;

    assign w_req = '{startAddr: i_upd_startAddr, fallthru: i_upd_fallthru, target: i_upd_target,
                     taken: i_upd_taken, branch_type: i_upd_branch_type,
                     hit_on_ftb: i_upd_hit_on_ftb, old_counter: i_upd_old_counter};

    ftb_upd_fifo #(.DEPTH(FIFO_DEPTH), .T(ftbUpdReq_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_upd_vld),
        .i_data  (w_req),
        .o_full  (w_full),
        .i_pop   (w_take),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // The output slot is free when empty or being drained this cycle; only then does the head move.
    assign w_free = !r_vld || i_ftb_wr_rdy;
    assign w_take = !w_empty && w_free;
    assign w_load = w_take && !w_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= 1'b0;
            r_idx   <= '0;
            r_entry <= '0;
        end else if (w_free) begin
            r_vld <= w_load;
            if (w_load) begin
                r_idx   <= w_head.startAddr[IDX_WIDTH:1];
                r_entry <= encodeEntry(w_head, IDX_WIDTH);
            end
        end
    end

`ifdef FTB_UPD_RANGE_CHECK_EN
    logic [15:0] r_drop_cnt;

    assign w_drop = !isEncodable(w_head);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                         r_drop_cnt <= '0;
        else if (w_take && w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    assign w_drop     = 1'b0;
    assign o_drop_cnt = '0;
`endif

    assign o_upd_rdy      = !w_full;
    assign o_ftb_wr_vld   = r_vld;
    assign o_ftb_wr_idx   = r_idx;
    assign o_ftb_wr_entry = r_entry;

endmodule
